// File: rtl/calc_responder.sv
// calc_responder: buffers x/y operand requests in a small FIFO, computes
// z = x + y over a fixed latency and returns it on a tagged valid/ready
// response channel.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/req_ready request handshake; x, y sampled on acceptance
//   rsp_valid/rsp_ready response handshake; z, rsp_tag held while valid
//   pending             outstanding requests (FIFO + in-flight)
//   busy                pending != 0
module calc_responder #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [DATA_W-1:0]           x,
    input  logic [DATA_W-1:0]           y,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W:0]             z,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic [$clog2(DEPTH+2)-1:0]  pending,
    output logic                        busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PEND_W = $clog2(DEPTH + 2);
    localparam int LAT_W  = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [DATA_W-1:0] mem_x   [DEPTH];
    logic [DATA_W-1:0] mem_y   [DEPTH];
    logic [TAG_W-1:0]  mem_tag [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TAG_W-1:0]  tag_ctr;

    logic [1:0]        state;
    logic [LAT_W-1:0]  cnt;
    logic [DATA_W-1:0] op_x;
    logic [DATA_W-1:0] op_y;
    logic [TAG_W-1:0]  op_tag;

    logic empty;
    logic push;
    logic pop;

    assign empty     = (count == '0);
    assign req_ready = (count != CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;

    // The head is taken either from IDLE or in the same edge a held
    // result is handed off; a freshly pushed entry is never bypassed.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == HOLD && rsp_ready)
                pop = 1'b1;
        end
    end

    assign pending = PEND_W'(count) + PEND_W'(state != IDLE);
    assign busy    = (pending != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr]   <= x;
            mem_y[wr_ptr]   <= y;
            mem_tag[wr_ptr] <= tag_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_ctr <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tag_ctr <= tag_ctr + TAG_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_x      <= '0;
            op_y      <= '0;
            op_tag    <= '0;
            rsp_valid <= 1'b0;
            z         <= '0;
            rsp_tag   <= '0;
        end else begin
            if (pop) begin
                op_x   <= mem_x[rd_ptr];
                op_y   <= mem_y[rd_ptr];
                op_tag <= mem_tag[rd_ptr];
                cnt    <= LAT_W'(LATENCY - 1);
            end
            case (state)
                IDLE: begin
                    if (pop)
                        state <= COMPUTE;
                end
                COMPUTE: begin
                    if (cnt == '0) begin
                        z         <= {1'b0, op_x} + {1'b0, op_y};
                        rsp_tag   <= op_tag;
                        rsp_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? COMPUTE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_responder.sv
// tb_calc_responder: directed and random stimulus for calc_responder,
// checked against an in-order queue model of outstanding requests.
module tb_calc_responder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int PW     = $clog2(DEPTH + 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W:0]   z;
    logic [TAG_W-1:0]  rsp_tag;
    logic [PW-1:0]     pending;
    logic              busy;

    calc_responder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LATENCY(2),
        .TAG_W  (TAG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .x        (x),
        .y        (y),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .z        (z),
        .rsp_tag  (rsp_tag),
        .pending  (pending),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } req_t;

    req_t             q[$];
    logic [TAG_W-1:0] tag_m;
    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_fail   = 0;
    logic             last_acc;
    logic             last_hs;
    logic [DATA_W:0]  last_z;
    logic [TAG_W-1:0] last_tag;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: note handshakes before the edge, update the model,
    // then check the outstanding-work outputs after the edge.
    task automatic cyc();
        logic            r, acc, hs, pv;
        logic [DATA_W:0] pz, ez;
        logic [TAG_W-1:0] pt;
        req_t            e;
        r   = rst;
        acc = (req_valid === 1'b1) && (req_ready === 1'b1);
        hs  = (rsp_valid === 1'b1) && (rsp_ready === 1'b1);
        pv  = (rsp_valid === 1'b1);
        pz  = z;
        pt  = rsp_tag;
        last_acc = acc && !r;
        last_hs  = hs && !r;
        if (r) begin
            q.delete();
            tag_m = '0;
        end else begin
            if (hs) begin
                check("rsp_expected", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    e  = q.pop_front();
                    ez = {1'b0, e.a} + {1'b0, e.b};
                    check("z", 32'(z), 32'(ez));
                    check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                    last_z   = z;
                    last_tag = rsp_tag;
                end
            end
            if (acc) begin
                e.a   = x;
                e.b   = y;
                e.tag = tag_m;
                q.push_back(e);
                tag_m = tag_m + TAG_W'(1);
            end
        end
        @(posedge clk);
        #1;
        if (!r) begin
            check("pending", 32'(pending), 32'(q.size()));
            check("busy", 32'(busy), 32'(q.size() != 0));
            check("req_ready", 32'(req_ready), 32'(q.size() <= DEPTH));
            if (pv && !hs) begin
                check("hold_valid", 32'(rsp_valid), 32'(1));
                check("hold_z", 32'(z), 32'(pz));
                check("hold_tag", 32'(rsp_tag), 32'(pt));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!last_hs && n < 50);
        check("rsp_seen", 32'(last_hs), 32'(1));
    endtask

    task automatic send_one(input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b);
        int n = 0;
        req_valid = 1'b1;
        x = a;
        y = b;
        do begin
            cyc();
            n++;
        end while (!last_acc && n < 20);
        req_valid = 1'b0;
        check("send_accept", 32'(last_acc), 32'(1));
        wait_rsp();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        x         = '0;
        y         = '0;
        tag_m     = '0;
        last_z    = '0;
        last_tag  = '0;
        last_acc  = 1'b0;
        last_hs   = 1'b0;

        // Reset values
        cyc();
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_z", 32'(z), 32'(0));
        check("rst_tag", 32'(rsp_tag), 32'(0));
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));

        // Single request, exact latency
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        x = 8'h05;
        y = 8'h03;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        check("lat_not_early", 32'(rsp_valid), 32'(0));
        cyc();
        check("lat_valid", 32'(rsp_valid), 32'(1));
        check("lat_z", 32'(z), 32'h008);
        check("lat_tag", 32'(rsp_tag), 32'(0));
        cyc();
        check("single_busy", 32'(busy), 32'(0));

        // Carry
        send_one(8'hFF, 8'hFF);
        check("carry_ff", 32'(last_z), 32'h1FE);
        send_one(8'h80, 8'h80);
        check("carry_80", 32'(last_z), 32'h100);

        // Back-pressure to full
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = 8'(8'h10 + i);
            y = 8'(i * 3);
            cyc();
            check("bp_accept", 32'(last_acc), 32'(1));
        end
        check("full_ready", 32'(req_ready), 32'(0));
        check("full_pending", 32'(pending), 32'(5));
        x = 8'hA5;
        y = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp_held_off", 32'(last_acc), 32'(0));
        end

        // Handshake at full with req_valid held high
        rsp_ready = 1'b1;
        cyc();
        check("pop_full_noacc", 32'(last_acc), 32'(0));
        check("pop_full_tag", 32'(last_tag), 32'(0));
        check("pop_full_pending", 32'(pending), 32'(4));
        check("pop_full_ready", 32'(req_ready), 32'(1));
        rsp_ready = 1'b0;
        cyc();
        check("sixth_accept", 32'(last_acc), 32'(1));
        check("sixth_pending", 32'(pending), 32'(5));
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_rsp();
            check("drain_tag", 32'(last_tag), 32'(k));
        end

        // Tag wrap
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send_one(8'($urandom), 8'($urandom));
            check("wrap_tag", 32'(last_tag), 32'(i % 16));
        end

        // Reset mid-operation
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 8'(i + 1);
            y = 8'(i + 7);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 1'b0;
        check("mid_rst_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_pending", 32'(pending), 32'(0));
        check("mid_rst_ready", 32'(req_ready), 32'(1));
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("mid_rst_quiet", 32'(rsp_valid), 32'(0));
        end
        rsp_ready = 1'b1;
        send_one(8'h01, 8'h02);
        check("post_rst_z", 32'(last_z), 32'h003);
        check("post_rst_tag", 32'(last_tag), 32'(0));

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom);
            rsp_ready = ($urandom_range(3, 0) != 0);
            x = 8'($urandom);
            y = 8'($urandom);
            cyc();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++)
            cyc();
        check("drained", 32'(q.size()), 32'(0));
        check("drained_busy", 32'(busy), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_responder.md
# calc_responder

DUT-side responder for the operand/result protocol that the testbench's example interface drives. The testbench presents 8-bit operand pairs `x`/`y` and waits for a 9-bit result `z`. This block buffers incoming requests in a small FIFO and computes `z = x + y` over a fixed multi-cycle latency. It returns each result on a valid/ready response channel with a sequence tag, so the initiator's poll-until-done loop can match responses to requests. It sits between the example interface signals and the arithmetic core, on the same clock as the interface.

## Interface
- `DATA_W`, 8: operand width; result width is `DATA_W+1`.
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `LATENCY`, 2: compute cycles per request; ≥1.
- `TAG_W`, 4: response sequence-tag width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: operand pair present.
- `req_ready`  out  1: FIFO can accept; equals FIFO not full.
- `x`  in  DATA_W: operand A, sampled on request handshake.
- `y`  in  DATA_W: operand B, sampled on request handshake.
- `rsp_valid`  out  1: result present on `z`/`rsp_tag`.
- `rsp_ready`  in  1: initiator consumes result.
- `z`  out  DATA_W+1: result `x + y`, zero-extended, no truncation.
- `rsp_tag`  out  TAG_W: sequence number of the request this result belongs to.
- `pending`  out  $clog2(DEPTH+2): FIFO occupancy + 1 if a request is in COMPUTE/HOLD.
- `busy`  out  1: `pending != 0`; this is the poll flag, nonzero while work is outstanding.

## Operation
- Request handshake: `req_valid && req_ready` at a rising edge pushes `{x, y, tag_ctr}` into the FIFO and increments `tag_ctr` (mod 2^TAG_W).
- FSM states:
  - **IDLE**: if the FIFO is non-empty, pop the head into the operand register, load `cnt = LATENCY-1`, and go to COMPUTE.
  - **COMPUTE**: decrement `cnt`. When `cnt == 0`, register `z = {1'b0,x} + {1'b0,y}` and `rsp_tag`, set `rsp_valid`, and go to HOLD.
  - **HOLD**: hold `z`, `rsp_tag` and `rsp_valid` stable until `rsp_ready`. On handshake, clear `rsp_valid`. If the FIFO is non-empty, pop in the same edge and go to COMPUTE; otherwise go to IDLE.
- FIFO full + pop on the same edge: `req_ready` is low, so no push occurs. `req_ready` rises the following cycle.
- FIFO empty + push in IDLE: no bypass. The entry is written, then popped on the next edge.
- `rsp_valid` never drops without a handshake. `z` and `rsp_tag` do not change while `rsp_valid` is high.
- Arithmetic: unsigned, result `DATA_W+1` bits, carry preserved (0xFF+0xFF = 0x1FE).
- `tag_ctr` wraps from 2^TAG_W−1 to 0 with no error.

## Timing
- Reset values, checked after the first `rst` edge: `req_ready=1`, `rsp_valid=0`, `z=0`, `rsp_tag=0`, `pending=0`, `busy=0`, `tag_ctr=0`, FIFO empty, FSM IDLE.
- `rst` during operation: all in-flight and buffered requests are discarded with no response. Outputs take their reset values at the reset edge. `req_valid` during `rst` is ignored.
- Latency (idle, empty): push at edge N → pop at N+1 → `rsp_valid` high after edge N+1+LATENCY. For LATENCY=2, that is 3 cycles after acceptance.
- Throughput with `rsp_ready` held high: one result every LATENCY+1 cycles.
- `pending`: increments on push, decrements on response handshake, unchanged on simultaneous push+handshake. Maximum value is DEPTH+1.

## Test plan
- **Single request**: reset, then push x=0x05, y=0x03 at edge 0 with `rsp_ready=1`. Required: `rsp_valid=1`, `z=0x008`, `rsp_tag=0` after edge 3; `busy=0` after the handshake at edge 4.
- **Carry**: push x=0xFF, y=0xFF. Required: `z=0x1FE`. Then push x=0x80, y=0x80. Required: `z=0x100`.
- **Back-pressure/full**: hold `rsp_ready=0` and push 6 requests back-to-back. Required: 5 accepted (1 in HOLD + 4 in FIFO); `req_ready=0`, `pending=5` after the 5th push; the 6th is held off. Then raise `rsp_ready`. Required: results drain in order with tags 0..4 and values unchanged while stalled.
- **Simultaneous push+pop at full**: with the FIFO full and `req_valid` held high, give a response handshake. Required: `pending` drops to 4, `req_ready` rises next cycle, the 6th request is accepted, and `pending` returns to 5.
- **Tag wrap**: 17 sequential requests. Required: `rsp_tag` sequence 0..15 then 0.
- **Reset mid-operation**: 3 requests queued, one in COMPUTE; assert `rst` for 1 cycle. Required: next cycle `rsp_valid=0`, `pending=0`, `req_ready=1`. A new request x=0x01, y=0x02 returns `z=0x003` with `rsp_tag=0`.
